// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART line assembler and the command parser.
//   state_e    - line assembler FSM encoding
//   CR/LF/BS/UNDERSCORE - framing and payload characters
//   LINE_W     - width of an assembled line, terminator included
//   is_ctrl()  - true for bytes the assembler never stores as payload
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        GOT_CR,
        HOLD,
        DISCARD
    } state_e;

    localparam logic [7:0] CR         = 8'h0D;
    localparam logic [7:0] LF         = 8'h0A;
    localparam logic [7:0] BS         = 8'h08;
    localparam logic [7:0] UNDERSCORE = 8'h5F;

    localparam int unsigned LINE_W = 120;

    function automatic logic is_ctrl(input logic [7:0] b);
        return (b == CR) || (b == LF) || (b == BS);
    endfunction

endpackage

// File: rtl/uart_line_assembler_if.sv
// uart_line_assembler_if: byte stream in, assembled line out.
//   RX_BYTE/RX_VALID        - received byte and its one-cycle strobe
//   LINE_DATA/LINE_LEN      - assembled line (right-aligned, CR LF included) and payload count
//   LINE_VALID/LINE_READY   - line handshake towards the command parser
//   ERR/DROP                - one-cycle event pulses
// Modports: slave = assembler, master = byte source plus line consumer.
interface uart_line_assembler_if;
    import uart_pkg::*;

    logic [7:0]        RX_BYTE;
    logic              RX_VALID;
    logic [LINE_W-1:0] LINE_DATA;
    logic              LINE_VALID;
    logic              LINE_READY;
    logic [3:0]        LINE_LEN;
    logic              ERR;
    logic              DROP;

    modport slave (
        input  RX_BYTE, RX_VALID, LINE_READY,
        output LINE_DATA, LINE_VALID, LINE_LEN, ERR, DROP
    );

    modport master (
        output RX_BYTE, RX_VALID, LINE_READY,
        input  LINE_DATA, LINE_VALID, LINE_LEN, ERR, DROP
    );

endinterface

// File: rtl/uart_idle_timer.sv
// uart_idle_timer: counts enabled cycles since the last clear and saturates at TIMEOUT_CYC.
//   CLK/RST  - clock, asynchronous active-high reset
//   clear    - restart the count from zero (wins over enable)
//   enable   - count this cycle; when low the count is frozen
//   expired  - count has reached TIMEOUT_CYC
module uart_idle_timer #(
    parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
    input  logic CLK,
    input  logic RST,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned      CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (enable && !expired) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign expired = (r_cnt == LIMIT);

endmodule

// File: rtl/uart_line_assembler.sv
// uart_line_assembler: collects UART bytes into CR LF terminated lines.
//   CLK/RST - clock, asynchronous active-high reset
//   bus     - slave side of uart_line_assembler_if (byte input, line handshake, ERR/DROP)
// Payload bytes are shifted in at [7:0]; backspace removes the newest byte. Over-long lines are
// swallowed up to the LF and reported with ERR. A completed line is held until accepted, and
// any byte arriving meanwhile is thrown away with a DROP pulse.
module uart_line_assembler
    import uart_pkg::*;
#(
    parameter int unsigned MAX_PAYLOAD = 13,
    parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
    input logic                  CLK,
    input logic                  RST,
    uart_line_assembler_if.slave bus
);

    localparam int unsigned BUF_W   = MAX_PAYLOAD * 8;
    localparam logic [3:0]  MAX_CNT = 4'(MAX_PAYLOAD);

    state_e            r_state;
    logic [BUF_W-1:0]  r_buf;
    logic [3:0]        r_count;
    logic [LINE_W-1:0] r_line_data;
    logic [3:0]        r_line_len;
    logic              r_line_valid;
    logic              r_err;
    logic              r_drop;

    logic w_expired;
    logic w_active;
    logic w_timeout;
    logic w_timer_clear;

    // A byte in the same cycle as expiry counts as activity, so the byte is processed instead.
    assign w_active      = (r_state == COLLECT) || (r_state == GOT_CR) || (r_state == DISCARD);
    assign w_timeout     = w_active && w_expired && !bus.RX_VALID;
    assign w_timer_clear = bus.RX_VALID || w_timeout;

    uart_idle_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_idle_timer (
        .CLK     (CLK),
        .RST     (RST),
        .clear   (w_timer_clear),
        .enable  (w_active),
        .expired (w_expired)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state      <= IDLE;
            r_buf        <= '0;
            r_count      <= '0;
            r_line_data  <= '0;
            r_line_len   <= '0;
            r_line_valid <= 1'b0;
            r_err        <= 1'b0;
            r_drop       <= 1'b0;
        end else begin
            r_err  <= 1'b0;
            r_drop <= 1'b0;
            if (w_timeout) begin
                r_err   <= 1'b1;
                r_buf   <= '0;
                r_count <= '0;
                r_state <= IDLE;
            end else begin
                unique case (r_state)
                    IDLE, COLLECT: begin
                        if (bus.RX_VALID) begin
                            if (bus.RX_BYTE == CR) begin
                                r_state <= GOT_CR;
                            end else if (bus.RX_BYTE == BS) begin
                                if (r_state == COLLECT) begin
                                    r_buf   <= r_buf >> 8;
                                    r_count <= r_count - 4'd1;
                                    if (r_count == 4'd1) begin
                                        r_state <= IDLE;
                                    end
                                end
                            end else if (!is_ctrl(bus.RX_BYTE)) begin
                                if (r_count < MAX_CNT) begin
                                    r_buf   <= {r_buf[BUF_W-9:0], bus.RX_BYTE};
                                    r_count <= r_count + 4'd1;
                                    r_state <= COLLECT;
                                end else begin
                                    r_state <= DISCARD;
                                end
                            end
                            // A stray LF outside GOT_CR carries no meaning and is ignored.
                        end
                    end
                    GOT_CR: begin
                        if (bus.RX_VALID) begin
                            if (bus.RX_BYTE == LF) begin
                                r_line_data  <= LINE_W'({r_buf, CR, LF});
                                r_line_len   <= r_count;
                                r_line_valid <= 1'b1;
                                r_state      <= HOLD;
                            end else begin
                                r_err   <= 1'b1;
                                r_state <= IDLE;
                            end
                            // Line content now lives in r_line_data; the buffer restarts empty.
                            r_buf   <= '0;
                            r_count <= '0;
                        end
                    end
                    HOLD: begin
                        if (bus.RX_VALID) begin
                            r_drop <= 1'b1;
                        end
                        if (r_line_valid && bus.LINE_READY) begin
                            r_line_valid <= 1'b0;
                            r_state      <= IDLE;
                        end
                    end
                    DISCARD: begin
                        if (bus.RX_VALID && (bus.RX_BYTE == LF)) begin
                            r_err   <= 1'b1;
                            r_buf   <= '0;
                            r_count <= '0;
                            r_state <= IDLE;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign bus.LINE_DATA  = r_line_data;
    assign bus.LINE_LEN   = r_line_len;
    assign bus.LINE_VALID = r_line_valid;
    assign bus.ERR        = r_err;
    assign bus.DROP       = r_drop;

endmodule

// File: tb/tb_uart_line_assembler.sv
// tb_uart_line_assembler: directed vectors for uart_line_assembler (TIMEOUT_CYC = 16).
// Inputs change on the falling edge; outputs are sampled 1 time unit after a falling edge.
module tb_uart_line_assembler;

    logic CLK;
    logic RST;

    uart_line_assembler_if bus ();

    uart_line_assembler #(
        .MAX_PAYLOAD (13),
        .TIMEOUT_CYC (16)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int   n_checks;
    int   n_fail;
    int   err_cnt;
    int   drop_cnt;
    int   both_cnt;
    int   lv_rise;
    logic lv_prev;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        err_cnt  = 0;
        drop_cnt = 0;
        both_cnt = 0;
        lv_rise  = 0;
        lv_prev  = 1'b0;
    end

    // Event pulses last one full cycle, so each is seen at exactly one falling edge.
    always @(negedge CLK) begin
        if (bus.ERR === 1'b1) err_cnt++;
        if (bus.DROP === 1'b1) drop_cnt++;
        if (bus.ERR === 1'b1 && bus.DROP === 1'b1) both_cnt++;
        if (bus.LINE_VALID === 1'b1 && lv_prev !== 1'b1) lv_rise++;
        lv_prev = bus.LINE_VALID;
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge CLK);
        bus.RX_BYTE  = b;
        bus.RX_VALID = 1'b1;
        @(negedge CLK);
        bus.RX_VALID = 1'b0;
        #1;
    endtask

    // Sends n bytes from v, most significant byte first.
    task automatic send_seq(input logic [127:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            send_byte(v[(n-1-i)*8 +: 8]);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
        #1;
    endtask

    task automatic accept();
        @(negedge CLK);
        bus.LINE_READY = 1'b1;
        @(negedge CLK);
        bus.LINE_READY = 1'b0;
        #1;
    endtask

    task automatic check_line(input string tag, input logic [119:0] data, input logic [3:0] len);
        check_eq({tag, "_valid"}, 128'(bus.LINE_VALID), 128'(1'b1));
        check_eq({tag, "_data"}, 128'(bus.LINE_DATA), 128'(data));
        check_eq({tag, "_len"}, 128'(bus.LINE_LEN), 128'(len));
    endtask

    int e0;
    int d0;
    int l0;

    initial begin
        RST            = 1'b1;
        bus.RX_BYTE    = 8'h00;
        bus.RX_VALID   = 1'b0;
        bus.LINE_READY = 1'b0;
        idle(2);
        check_eq("rst_data", 128'(bus.LINE_DATA), 128'h0);
        check_eq("rst_valid", 128'(bus.LINE_VALID), 128'h0);
        check_eq("rst_len", 128'(bus.LINE_LEN), 128'h0);
        check_eq("rst_err", 128'(bus.ERR), 128'h0);
        check_eq("rst_drop", 128'(bus.DROP), 128'h0);
        @(negedge CLK);
        RST = 1'b0;
        idle(2);

        // Basic line: R_05
        send_seq(128'h525F30350D, 5);
        check_eq("basic_valid_before_lf", 128'(bus.LINE_VALID), 128'h0);
        send_byte(8'h0A);
        check_line("basic", 120'h525F_3035_0D0A, 4'd4);
        accept();
        check_eq("basic_accepted", 128'(bus.LINE_VALID), 128'h0);

        // Backspace corrects 8 to 5
        send_seq(128'h525F303808350D0A, 8);
        check_line("bs", 120'h525F_3035_0D0A, 4'd4);
        accept();

        // Empty line
        send_seq(128'h0D0A, 2);
        check_line("empty", 120'h0D0A, 4'd0);
        accept();

        // Backspace down to empty, then once more in IDLE (ignored)
        send_seq(128'h4108080D0A, 5);
        check_line("bs_to_empty", 120'h0D0A, 4'd0);
        accept();

        // Overflow: 14 payload bytes, then CR LF
        e0 = err_cnt;
        l0 = lv_rise;
        for (int i = 0; i < 14; i++) send_byte(8'h41);
        send_byte(8'h0D);
        check_eq("ovf_no_err_before_lf", 128'(err_cnt - e0), 128'h0);
        send_byte(8'h0A);
        check_eq("ovf_err_at_lf", 128'(bus.ERR), 128'h1);
        idle(3);
        check_eq("ovf_err_once", 128'(err_cnt - e0), 128'h1);
        check_eq("ovf_no_line", 128'(lv_rise - l0), 128'h0);
        send_seq(128'h41420D0A, 4);
        check_line("after_ovf", 120'h4142_0D0A, 4'd2);
        accept();

        // Bad terminator: byte after CR is not LF
        e0 = err_cnt;
        send_seq(128'h410D42, 3);
        check_eq("badterm_err", 128'(bus.ERR), 128'h1);
        idle(2);
        check_eq("badterm_err_once", 128'(err_cnt - e0), 128'h1);
        send_seq(128'h0D0A, 2);
        check_line("after_badterm", 120'h0D0A, 4'd0);
        accept();

        // Pending line held against back-pressure; extra bytes are dropped
        d0 = drop_cnt;
        send_seq(128'h330D0A, 3);
        idle(10);
        check_eq("hold_valid", 128'(bus.LINE_VALID), 128'h1);
        send_byte(8'h41);
        check_eq("hold_drop", 128'(bus.DROP), 128'h1);
        check_eq("hold_data", 128'(bus.LINE_DATA), 128'h330D0A);
        check_eq("hold_len", 128'(bus.LINE_LEN), 128'h1);
        idle(1);
        check_eq("hold_drop_once", 128'(drop_cnt - d0), 128'h1);
        // Byte arriving in the acceptance cycle is dropped as well
        @(negedge CLK);
        bus.LINE_READY = 1'b1;
        bus.RX_BYTE    = 8'h41;
        bus.RX_VALID   = 1'b1;
        @(negedge CLK);
        bus.LINE_READY = 1'b0;
        bus.RX_VALID   = 1'b0;
        #1;
        check_eq("accept_drop", 128'(bus.DROP), 128'h1);
        check_eq("accept_valid_low", 128'(bus.LINE_VALID), 128'h0);
        idle(1);
        check_eq("drop_total", 128'(drop_cnt - d0), 128'h2);

        // Idle timeout discards partial line
        e0 = err_cnt;
        send_seq(128'h525F, 2);
        idle(14);
        check_eq("timeout_not_early", 128'(err_cnt - e0), 128'h0);
        idle(8);
        check_eq("timeout_err_once", 128'(err_cnt - e0), 128'h1);
        send_seq(128'h0D0A, 2);
        check_line("after_timeout", 120'h0D0A, 4'd0);
        accept();

        // Reset during HOLD clears outputs asynchronously, without ERR
        e0 = err_cnt;
        send_seq(128'h410D0A, 3);
        check_line("pre_rst", 120'h41_0D0A, 4'd1);
        @(negedge CLK);
        #2;
        RST = 1'b1;
        #1;
        check_eq("arst_valid", 128'(bus.LINE_VALID), 128'h0);
        check_eq("arst_data", 128'(bus.LINE_DATA), 128'h0);
        check_eq("arst_len", 128'(bus.LINE_LEN), 128'h0);
        @(negedge CLK);
        RST = 1'b0;
        idle(2);

        // Reset mid-line abandons the partial buffer
        send_seq(128'h4142, 2);
        @(negedge CLK);
        #2;
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        idle(2);
        check_eq("rst_no_err", 128'(err_cnt - e0), 128'h0);
        send_seq(128'h0D0A, 2);
        check_line("after_rst", 120'h0D0A, 4'd0);
        accept();

        check_eq("err_drop_exclusive", 128'(both_cnt), 128'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_line_assembler.md
UART_LINE_ASSEMBLER -- requirements
Module: uart_line_assembler

Interface
REQ-001 SHALL have parameter MAX_PAYLOAD, default 13, meaning the maximum number of payload bytes per line, excluding CR/LF.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1_000_000, meaning the number of idle CLK cycles after which a partial line is discarded.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port RX_BYTE, input, 8 bits: received UART byte.
REQ-006 SHALL have port RX_VALID, input, 1 bit: RX_BYTE is valid this cycle; single-cycle strobe per byte.
REQ-007 SHALL have port LINE_DATA, output, 120 bits: assembled line, right-aligned.
REQ-008 SHALL have port LINE_VALID, output, 1 bit: LINE_DATA/LINE_LEN are valid; held until accepted.
REQ-009 SHALL have port LINE_READY, input, 1 bit: the downstream command parser accepts the line.
REQ-010 SHALL have port LINE_LEN, output, 4 bits: payload byte count, 0..MAX_PAYLOAD.
REQ-011 SHALL have port ERR, output, 1 bit: one-cycle pulse on overflow, bad terminator or timeout.
REQ-012 SHALL have port DROP, output, 1 bit: one-cycle pulse when a byte is discarded because a line is pending.

Function
REQ-013 SHALL implement FSM states IDLE (buffer empty), COLLECT, GOT_CR, HOLD and DISCARD.
REQ-014 SHALL, in IDLE or COLLECT on a non-control byte with count < MAX_PAYLOAD, shift the buffer left 8 bits, insert the byte at [7:0], increment count and go to COLLECT.
REQ-015 SHALL, on byte 0x0D in IDLE or COLLECT, go to GOT_CR; the CR is not stored.
REQ-016 SHALL, on byte 0x0A in GOT_CR, set LINE_DATA = {buffer, 16'h0D0A} zero-extended on the upper bits and LINE_LEN = count, then enter HOLD; LINE_VALID rises the cycle after the LF is sampled.
REQ-017 SHALL, on any byte other than 0x0A in GOT_CR, pulse ERR, clear the buffer, drop that byte and return to IDLE.
REQ-018 SHALL, on byte 0x08 (backspace) in COLLECT, shift the buffer right 8 bits and decrement count, entering IDLE if count reaches 0; in IDLE, backspace is ignored.
REQ-019 SHALL, on a payload byte received with count == MAX_PAYLOAD, enter DISCARD; DISCARD ignores bytes until 0x0A, then pulses ERR, clears the buffer and enters IDLE with no line emitted.
REQ-020 SHALL, in HOLD, keep LINE_VALID=1 and LINE_DATA/LINE_LEN stable until LINE_VALID & LINE_READY, then enter IDLE with LINE_VALID=0 on the next cycle.
REQ-021 SHALL, on any RX_VALID in HOLD (including the acceptance cycle), drop the byte and pulse DROP.
REQ-022 SHALL reset an idle counter on every RX_VALID; in COLLECT, GOT_CR or DISCARD, the counter reaching TIMEOUT_CYC pulses ERR, clears the buffer and enters IDLE. The counter is frozen in IDLE and HOLD.
REQ-023 SHALL treat an empty line (CR LF from IDLE) as valid: LINE_DATA = 120'h0D0A, LINE_LEN = 0.
REQ-024 SHALL have ERR and DROP each asserted for exactly one cycle per event, never both in the same cycle.

Reset
REQ-025 SHALL, while RST=1, asynchronously force: state IDLE, buffer 0, count 0, idle counter 0, LINE_DATA 0, LINE_VALID 0, LINE_LEN 0, ERR 0, DROP 0.
REQ-026 SHALL, when RST is asserted mid-line or during HOLD, abandon the pending line with no ERR pulse.

Structure
REQ-027 SHALL place the state encoding and the constants CR=8'h0D, LF=8'h0A, BS=8'h08, UNDERSCORE=8'h5F and LINE_W=120 in shared package uart_pkg, which is also used by the command parser.
REQ-028 SHALL implement the idle counter as sub-module uart_idle_timer, with ports clear, enable and expired.

Verification
REQ-029 SHALL verify: bytes 52 5F 30 35 0D 0A -> LINE_DATA = 120'h525F_3035_0D0A, LINE_LEN = 4, LINE_VALID one cycle after the LF.
REQ-030 SHALL verify: bytes 52 5F 30 38 08 35 0D 0A -> identical result to REQ-029.
REQ-031 SHALL verify: 0D 0A from IDLE -> LINE_DATA = 120'h0D0A, LINE_LEN = 0.
REQ-032 SHALL verify: 14 x 41 then 0D 0A -> no LINE_VALID, a single ERR pulse at the LF, next line assembled normally.
REQ-033 SHALL verify: line pending, LINE_READY=0 for 10 cycles and byte 41 sent -> DROP pulse, LINE_DATA unchanged; LINE_READY=1 -> LINE_VALID=0 next cycle.
REQ-034 SHALL verify (TIMEOUT_CYC=16): 52 5F then 16 idle cycles -> ERR pulse; then 0D 0A -> empty line; RST mid-line -> all outputs 0 immediately.
